layer5_fc_argmax: RTL and testbench
===================================

Name: layer5_fc_argmax

Overview:
- Final classifier stage. Sits directly downstream of the 84-output fully connected layer.
- Captures that layer's 84-wide vector (84 x 16-bit signed) on its finish pulse and applies ReLU.
- Streams the 84 activations through 10 MAC lanes against a weight ROM addressed by this block, adds the biases, then runs a sequential argmax.
- Outputs the predicted class 0..9 with a done pulse.

Parameters:
- N_IN, 84, input vector length.
- N_OUT, 10, number of classes / MAC lanes.
- DW, 16, data/weight/bias width, signed fixed point.
- FRAC, 8, fractional bits of all DW-wide operands.
- ACC_W, 40, accumulator width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-low reset.
- din  in  N_IN*DW  activation vector; element 0 in the MSBs.
- start  in  1  one-cycle pulse; din is valid in that cycle.
- weight_in  in  N_OUT*DW  weight row for w_addr; class 0 in the MSBs; valid 1 cycle after w_addr.
- bias_in  in  N_OUT*DW  static biases; class 0 in the MSBs.
- w_addr  out  7  weight ROM row address.
- busy  out  1  high from the start capture until done.
- done  out  1  one-cycle pulse; class_out is valid from this cycle.
- class_out  out  4  predicted class index.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; busy=0, done=0, class_out=0, w_addr=0.
  - Activation bank, accumulators and logits cleared.
  - Applies mid-operation too: any run in progress is abandoned and no done pulse follows.
- States: IDLE -> MAC -> BIAS -> ARGMAX -> DONE -> IDLE.
- IDLE:
  - When start=1 at edge E0: register x[i]=max(din[i],0) for all i; cnt=0; w_addr=0; busy=1; go to MAC.
  - start with busy=1 is ignored; no re-capture.
- MAC, cnt=0..N_IN (85 cycles):
  - w_addr=cnt while cnt<N_IN, held at N_IN-1 afterwards.
  - For cnt>=1: acc[j] += x[cnt-1]*w[j] for every lane j.
  - Each product is a full 2*DW-bit signed product, sign-extended to ACC_W. No intermediate truncation.
  - Leave MAC after cnt==N_IN.
- BIAS (1 cycle):
  - logit[j] = sat_DW((acc[j] + (sext(bias[j])<<FRAC)) >>> FRAC).
  - Arithmetic shift, floor rounding.
  - Saturate to [-32768, 32767].
- ARGMAX (N_OUT cycles):
  - Best starts as logit[0], index 0.
  - For j=1..9: replace best only when logit[j] > best (strict), so ties resolve to the lowest index.
- DONE (1 cycle):
  - done=1; class_out updated in the same cycle; busy=0.
  - Return to IDLE.
  - class_out holds until the next done or a reset.
- Latency: done is high in the cycle after edge E0+97. start may be re-accepted in the first IDLE cycle after done.
- Accumulators clear at each start capture, never carried between runs.
- The ROM is a synchronous read with one cycle of latency. The block never stalls.

Optional Feature:
- Macro LAYER5_LOGITS_OUT_EN.
- Defined: adds output port logits_out (N_OUT*DW, class 0 in the MSBs).
  - Carries the saturated logits from the BIAS cycle onward.
  - Held until the next BIAS cycle.
  - Reset value 0.
- Undefined: port and logit export logic are absent; class_out/done behaviour is identical.

Test Plan:
- din all 16'h0100; weight row for class j = 16*j raw in every row; bias 0 -> logit_j=1344*j; class_out=9; done in the cycle after E0+97; w_addr sweeps 0..83.
- din all 16'hFF00 (-1.0); any weights; bias_j=16'h0100*j -> ReLU zeroes the inputs; logits equal bias; class_out=9.
- All weights 0; bias all 16'h0080 -> tie; class_out=0. Same with only bias[3]=16'h0081 -> class_out=3.
- din all 16'h7FFF; class 2 weights 16'h7FFF, others 0; bias 0 -> logit_2 saturates to 32767 (visible with LAYER5_LOGITS_OUT_EN); class_out=2.
- Second start pulse 10 cycles after the first -> ignored; exactly one done pulse; result from the first din.
- reset=0 at E0+40, then a new start -> no done from the first run; the second run's done arrives exactly 97 cycles after its start; busy=0 right after reset.

Source files
------------

// File: rtl/layer5_fc_argmax.sv
// ============================================================================
// Module   : layer5_fc_argmax
// Purpose  : Final classifier. ReLU on an 84-wide vector, 10-lane MAC against
//            an external weight ROM, bias and saturation, then sequential argmax.
//            Optional macro LAYER5_LOGITS_OUT_EN exports the saturated logits.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module layer5_fc_argmax #(
    parameter int N_IN  = 84,
    parameter int N_OUT = 10,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*DW-1:0]    din,
    input  logic                  start,
    input  logic [N_OUT*DW-1:0]   weight_in,
    input  logic [N_OUT*DW-1:0]   bias_in,
    output logic [6:0]            w_addr,
    output logic                  busy,
    output logic                  done,
`ifdef LAYER5_LOGITS_OUT_EN
    output logic [N_OUT*DW-1:0]   logits_out,
`endif
    output logic [3:0]            class_out
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_mac    = 3'd1;
    localparam logic [2:0] c_st_bias   = 3'd2;
    localparam logic [2:0] c_st_argmax = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    localparam logic [6:0] c_n_in      = 7'(N_IN);
    localparam logic [6:0] c_last_addr = 7'(N_IN - 1);
    localparam logic [3:0] c_last_cls  = 4'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] c_sat_min = -c_sat_max - 1;

    logic [2:0]                r_state;
    logic [6:0]                r_cnt;
    logic [3:0]                r_aidx;
    logic [3:0]                r_best_idx;
    logic signed [DW-1:0]      r_best;
    logic signed [DW-1:0]      r_x     [N_IN];
    logic signed [ACC_W-1:0]   r_acc   [N_OUT];
    logic signed [DW-1:0]      r_logit [N_OUT];

    logic signed [DW-1:0]      w_relu     [N_IN];
    logic signed [ACC_W-1:0]   w_prod_ext [N_OUT];
    logic signed [DW-1:0]      w_sat      [N_OUT];
    logic [6:0]                w_xidx;
    logic [6:0]                w_cnt_nxt;
    logic signed [DW-1:0]      w_x_cur;

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_din
            logic [DW-1:0] w_elem;
            assign w_elem     = din[(N_IN-1-gi)*DW +: DW];
            assign w_relu[gi] = w_elem[DW-1] ? '0 : w_elem;
        end
    endgenerate

    // Weight row for x[cnt-1] arrives in the cnt cycle because of ROM latency.
    assign w_xidx    = (r_cnt == 7'd0) ? 7'd0 : r_cnt - 7'd1;
    assign w_x_cur   = r_x[w_xidx];
    assign w_cnt_nxt = r_cnt + 7'd1;

    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_lane
            logic signed [DW-1:0]    w_wt;
            logic signed [DW-1:0]    w_b;
            logic signed [2*DW-1:0]  w_prod;
            logic signed [ACC_W-1:0] w_sum;
            logic signed [ACC_W-1:0] w_shift;
            assign w_wt   = weight_in[(N_OUT-1-gi)*DW +: DW];
            assign w_b    = bias_in[(N_OUT-1-gi)*DW +: DW];
            assign w_prod = $signed({{DW{w_x_cur[DW-1]}}, w_x_cur})
                          * $signed({{DW{w_wt[DW-1]}}, w_wt});
            assign w_prod_ext[gi] = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
            assign w_sum   = r_acc[gi]
                           + $signed({{(ACC_W-DW-FRAC){w_b[DW-1]}}, w_b, {FRAC{1'b0}}});
            assign w_shift = w_sum >>> FRAC;
            assign w_sat[gi] = (w_shift > c_sat_max) ? c_sat_max[DW-1:0] :
                               (w_shift < c_sat_min) ? c_sat_min[DW-1:0] :
                               w_shift[DW-1:0];
        end
    endgenerate

`ifdef LAYER5_LOGITS_OUT_EN
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_logits_out
            assign logits_out[(N_OUT-1-gi)*DW +: DW] = r_logit[gi];
        end
    endgenerate
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_cnt      <= 7'd0;
            r_aidx     <= 4'd0;
            r_best_idx <= 4'd0;
            r_best     <= '0;
            w_addr     <= 7'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            class_out  <= 4'd0;
            for (int i = 0; i < N_IN; i++)  r_x[i]     <= '0;
            for (int j = 0; j < N_OUT; j++) r_acc[j]   <= '0;
            for (int j = 0; j < N_OUT; j++) r_logit[j] <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        for (int i = 0; i < N_IN; i++)  r_x[i]   <= w_relu[i];
                        for (int j = 0; j < N_OUT; j++) r_acc[j] <= '0;
                        r_cnt   <= 7'd0;
                        w_addr  <= 7'd0;
                        busy    <= 1'b1;
                        r_state <= c_st_mac;
                    end
                end
                c_st_mac: begin
                    if (r_cnt != 7'd0) begin
                        for (int j = 0; j < N_OUT; j++) r_acc[j] <= r_acc[j] + w_prod_ext[j];
                    end
                    w_addr <= (w_cnt_nxt < c_n_in) ? w_cnt_nxt : c_last_addr;
                    if (r_cnt == c_n_in) begin
                        r_state <= c_st_bias;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                c_st_bias: begin
                    for (int j = 0; j < N_OUT; j++) r_logit[j] <= w_sat[j];
                    r_aidx  <= 4'd0;
                    r_state <= c_st_argmax;
                end
                c_st_argmax: begin
                    // Strict compare keeps the lowest index on ties.
                    if (r_aidx == 4'd0) begin
                        r_best     <= r_logit[0];
                        r_best_idx <= 4'd0;
                    end else if (r_logit[r_aidx] > r_best) begin
                        r_best     <= r_logit[r_aidx];
                        r_best_idx <= r_aidx;
                    end
                    if (r_aidx == c_last_cls) begin
                        r_state <= c_st_done;
                    end else begin
                        r_aidx <= r_aidx + 4'd1;
                    end
                end
                c_st_done: begin
                    done      <= 1'b1;
                    class_out <= r_best_idx;
                    busy      <= 1'b0;
                    r_state   <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_layer5_fc_argmax.sv
// Bench for layer5_fc_argmax: directed and random vectors against an arithmetic
// reference model, plus latency, ignored-start and mid-run reset scenarios.
`default_nettype none

module tb_layer5_fc_argmax;

    localparam int N_IN  = 84;
    localparam int N_OUT = 10;
    localparam int DW    = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic [N_IN*DW-1:0]   din = '0;
    logic [N_OUT*DW-1:0]  weight_in = '0;
    logic [N_OUT*DW-1:0]  bias_in = '0;
    logic [6:0]           w_addr;
    logic                 busy;
    logic                 done;
    logic [3:0]           class_out;
`ifdef LAYER5_LOGITS_OUT_EN
    logic [N_OUT*DW-1:0]  logits_out;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    shortint din_v [N_IN];
    shortint w_v   [N_IN][N_OUT];
    shortint b_v   [N_OUT];
    shortint exp_lg[N_OUT];
    int      exp_cls;
    logic [N_OUT*DW-1:0] rom [128];

    layer5_fc_argmax dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .start      (start),
        .weight_in  (weight_in),
        .bias_in    (bias_in),
        .w_addr     (w_addr),
        .busy       (busy),
        .done       (done),
`ifdef LAYER5_LOGITS_OUT_EN
        .logits_out (logits_out),
`endif
        .class_out  (class_out)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one cycle of read latency.
    always @(posedge clk) weight_in <= rom[w_addr];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pack vectors into buses/ROM and compute expected logits and class.
    task automatic load_and_model();
        longint acc;
        longint lg;
        for (int i = 0; i < N_IN; i++) din[(N_IN-1-i)*DW +: DW] = din_v[i];
        for (int a = 0; a < 128; a++) rom[a] = '0;
        for (int a = 0; a < N_IN; a++)
            for (int j = 0; j < N_OUT; j++) rom[a][(N_OUT-1-j)*DW +: DW] = w_v[a][j];
        for (int j = 0; j < N_OUT; j++) bias_in[(N_OUT-1-j)*DW +: DW] = b_v[j];
        for (int j = 0; j < N_OUT; j++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++)
                if (din_v[i] > 0) acc += longint'(din_v[i]) * longint'(w_v[i][j]);
            acc += longint'(b_v[j]) * 256;
            lg = acc >>> 8;
            if (lg > 32767)  lg = 32767;
            if (lg < -32768) lg = -32768;
            exp_lg[j] = shortint'(lg);
        end
        exp_cls = 0;
        for (int j = 1; j < N_OUT; j++) if (exp_lg[j] > exp_lg[exp_cls]) exp_cls = j;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N_IN; i++) begin
            din_v[i] = shortint'(int'($urandom_range(0, 1023)) - 512);
            for (int j = 0; j < N_OUT; j++)
                w_v[i][j] = shortint'(int'($urandom_range(0, 511)) - 256);
        end
        for (int j = 0; j < N_OUT; j++) b_v[j] = shortint'(int'($urandom_range(0, 4095)) - 2048);
    endtask

    task automatic run_case(input string name, input int inj_k, input bit chk_sweep);
        int lat;
        bit sweep_ok;
        int exp_addr;
        load_and_model();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, ":busy_at_start"}, longint'(busy), 1);
        check({name, ":w_addr_at_start"}, longint'(w_addr), 0);
        lat = -1;
        sweep_ok = 1'b1;
        for (int k = 1; k <= 200 && lat < 0; k++) begin
            if (inj_k > 0 && k == inj_k) begin
                start = 1'b1;
                for (int w = 0; w < N_IN*DW/32; w++) din[w*32 +: 32] = $urandom;
            end
            @(posedge clk); #1;
            if (inj_k > 0 && k == inj_k) start = 1'b0;
            exp_addr = (k < 83) ? k : 83;
            if (k <= 85 && int'(w_addr) != exp_addr) sweep_ok = 1'b0;
            if (done) lat = k;
        end
        check({name, ":latency"}, longint'(lat), 97);
        check({name, ":class_out"}, longint'(class_out), longint'(exp_cls));
        check({name, ":busy_at_done"}, longint'(busy), 0);
        if (chk_sweep) check({name, ":w_addr_sweep"}, longint'(sweep_ok), 1);
`ifdef LAYER5_LOGITS_OUT_EN
        for (int j = 0; j < N_OUT; j++)
            check({name, ":logit"}, longint'($signed(logits_out[(N_OUT-1-j)*DW +: DW])),
                  longint'(exp_lg[j]));
`endif
        @(posedge clk); #1;
        check({name, ":done_single_pulse"}, longint'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:busy", longint'(busy), 0);
        check("reset:done", longint'(done), 0);
        check("reset:class_out", longint'(class_out), 0);
        check("reset:w_addr", longint'(w_addr), 0);
`ifdef LAYER5_LOGITS_OUT_EN
        check("reset:logits_out", longint'(logits_out == '0), 1);
`endif
        reset = 1'b1;

        // Unit inputs, weight 16*j raw -> logit 1344*j.
        for (int i = 0; i < N_IN; i++) begin
            din_v[i] = 16'sh0100;
            for (int j = 0; j < N_OUT; j++) w_v[i][j] = shortint'(16 * j);
        end
        for (int j = 0; j < N_OUT; j++) b_v[j] = 0;
        run_case("ramp", 0, 1'b1);
        check("ramp:model_logit9", longint'(exp_lg[9]), 12096);

        // Mid-run reset abandons the run.
        rand_data();
        load_and_model();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k < 40; k++) begin
            if (k == 39) reset = 1'b0;
            @(posedge clk); #1;
        end
        check("midreset:busy", longint'(busy), 0);
        check("midreset:done", longint'(done), 0);
        check("midreset:class_out", longint'(class_out), 0);
        check("midreset:w_addr", longint'(w_addr), 0);
        reset = 1'b1;
        dones = 0;
        for (int k = 0; k < 110; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("midreset:no_done", longint'(dones), 0);
        rand_data();
        run_case("after_reset", 0, 1'b1);

        // Negative inputs are zeroed; logits equal the biases.
        rand_data();
        for (int i = 0; i < N_IN; i++) din_v[i] = -16'sh0100;
        for (int j = 0; j < N_OUT; j++) b_v[j] = shortint'(256 * j);
        run_case("relu_neg", 0, 1'b0);

        // All-zero weights with equal biases: tie goes to class 0.
        for (int i = 0; i < N_IN; i++)
            for (int j = 0; j < N_OUT; j++) w_v[i][j] = 0;
        for (int j = 0; j < N_OUT; j++) b_v[j] = 16'sh0080;
        run_case("tie", 0, 1'b0);
        b_v[3] = 16'sh0081;
        run_case("tie_b3", 0, 1'b0);

        // Saturation of class 2.
        for (int i = 0; i < N_IN; i++) begin
            din_v[i] = 16'sh7FFF;
            for (int j = 0; j < N_OUT; j++) w_v[i][j] = (j == 2) ? 16'sh7FFF : 16'sh0000;
        end
        for (int j = 0; j < N_OUT; j++) b_v[j] = 0;
        run_case("saturate", 0, 1'b0);

        // Second start while busy must be ignored.
        rand_data();
        run_case("restart_ignored", 10, 1'b0);

        for (int r = 0; r < 3; r++) begin
            rand_data();
            run_case("random", 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
